// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: read-owner encoding and default starvation limit shared by the RAM arbiter files
package ram_arbiter_pkg;
  typedef enum logic [1:0] {PORT_NONE = 2'd0, PORT_0 = 2'd1, PORT_1 = 2'd2} port_e;
  localparam int MAX_STREAK_DEF = 4;
endpackage

// File: rtl/ram_arbiter_arb_prio_limit.sv
// arb_prio_limit: fixed priority to port 0, with a streak limit that forces a port-1 grant
module arb_prio_limit
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak;
  logic          lim;
  always_comb begin
    lim  = streak == SW'(MAX_STREAK);
    gnt0 = reset_n && req0 && !(req1 && lim);
    gnt1 = reset_n && req1 && !gnt0;
  end
  // the streak only counts port-0 wins while port 1 is actually waiting
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) streak <= '0;
    else if (!req1 || gnt1) streak <= '0;
    else if (gnt0 && !lim) streak <= streak + 1'b1;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between the CPU port (0) and the debug/loader port (1)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_wr_sig,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);
  port_e             rd_owner;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  arb_prio_limit #(.MAX_STREAK(MAX_STREAK)) u_arb (
    .clk(clk), .reset_n(reset_n), .req0(m0_req), .req1(m1_req), .gnt0(m0_gnt), .gnt1(m1_gnt)
  );
  always_comb begin
    ram_wr_sig  = m0_gnt ? m0_wr : m1_gnt && m1_wr;
    ram_addr    = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
    ram_wr_data = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
    m0_rvalid   = rd_owner == PORT_0;
    m1_rvalid   = rd_owner == PORT_1;
    m0_rdata    = m0_rvalid ? ram_rd_data : rdata0_q;
    m1_rdata    = m1_rvalid ? ram_rd_data : rdata1_q;
  end
  // RAM data arrives the cycle after the grant; hold copies keep rdata stable afterwards
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_owner <= PORT_NONE;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rd_owner <= m0_gnt && !m0_wr ? PORT_0 : m1_gnt && !m1_wr ? PORT_1 : PORT_NONE;
      if (m0_rvalid) rdata0_q <= ram_rd_data;
      if (m1_rvalid) rdata1_q <= ram_rd_data;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  localparam int MAXS = 4;
  logic        clk = 0, reset_n = 0;
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_wr_sig;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wr_data, ram_rd_data = 0;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int          total = 0, bad = 0;
  int          wins = 0, pend = -1;
  logic [31:0] pend_data = 0, last0 = 0, last1 = 0;
  logic        g0, g1, rv1;

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wr_sig(ram_wr_sig), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_sig) ram[ram_addr[7:0]] <= ram_wr_data;
    ram_rd_data <= ram[ram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive requests, check everything visible this cycle, advance the model
  task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic e0, e1, ew;
    logic [31:0] ea, ed;
    m0_req = r0; m0_wr = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    if (!reset_n) begin
      pend = -1; wins = 0; last0 = 0; last1 = 0;
    end
    e0 = reset_n && r0 && !(r1 && wins >= MAXS);
    e1 = reset_n && r1 && !e0;
    ew = e0 ? w0 : e1 && w1;
    ea = e0 ? a0 : e1 ? a1 : 32'd0;
    ed = e0 ? d0 : e1 ? d1 : 32'd0;
    chk("gnt0", m0_gnt, e0);
    chk("gnt1", m1_gnt, e1);
    chk("ram_wr_sig", ram_wr_sig, ew);
    chk("ram_addr", ram_addr, ea);
    chk("ram_wr_data", ram_wr_data, ed);
    chk("rvalid0", m0_rvalid, pend == 0);
    chk("rvalid1", m1_rvalid, pend == 1);
    chk("rdata0", m0_rdata, pend == 0 ? pend_data : last0);
    chk("rdata1", m1_rdata, pend == 1 ? pend_data : last1);
    g0 = m0_gnt; g1 = m1_gnt; rv1 = m1_rvalid;
    if (pend == 0) last0 = pend_data;
    if (pend == 1) last1 = pend_data;
    pend = e0 && !w0 ? 0 : e1 && !w1 ? 1 : -1;
    pend_data = ref_mem[ea[7:0]];
    if (ew) ref_mem[ea[7:0]] = ed;
    if (!reset_n || e1 || !r1) wins = 0;
    else if (e0 && wins < MAXS) wins++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp3 [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    logic pr0, pw0, pr1, pw1;
    logic [31:0] pa0, pd0, pa1, pd1;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 0;
      ref_mem[i] = 0;
    end
    @(posedge clk);
    #1;
    // reset held with both requesting, then release
    repeat (2) cyc(1, 1, 32'h4, 32'h1, 1, 1, 32'h8, 32'h2);
    chk("t1_no_gnt", {g0, g1}, 2'b00);
    reset_n = 1;
    cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    chk("t1_first_gnt0", g0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // write then read back on port 0
    cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("t2_read_gnt0", g0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rdata", m0_rdata, 32'hDEADBEEF);
    // sustained contention: streak limit forces port 1 every fifth grant
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
      chk("t3_gnt1_seq", g1, exp3[i]);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // alternating back-to-back reads from distinct ports
    cyc(1, 1, 32'h4, 32'h44444444, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h8, 32'h88888888);
    for (int i = 0; i < 6; i++)
      if (i % 2 == 0) cyc(1, 0, 32'h4, 0, 0, 0, 0, 0);
      else cyc(0, 0, 0, 0, 1, 0, 32'h8, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_last_rdata0", m0_rdata, 32'h44444444);
    chk("t4_last_rdata1", m1_rdata, 32'h88888888);
    // reset in the cycle after a port-1 read grant
    cyc(0, 0, 0, 0, 1, 0, 32'h8, 0);
    reset_n = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_rvalid1_dropped", rv1, 0);
    reset_n = 1;
    repeat (3) cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    reset_n = 0;
    cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      chk("t5_streak_cleared", g1, i == 4);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // port 1 writes, port 0 reads it back
    cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h5A);
    chk("t6_gnt1", g1, 1);
    cyc(1, 0, 32'h20, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_rdata0", m0_rdata, 32'h5A);
    // random traffic honouring the hold-until-grant rule, with occasional withdrawal
    pr0 = 0; pr1 = 0; pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1);
      if (!(pr0 && !g0 && $urandom_range(9) != 0)) begin
        pr0 = $urandom_range(9) < 7; pw0 = 1'($urandom_range(1));
        pa0 = {26'd0, 4'($urandom_range(15)), 2'b00}; pd0 = $urandom;
      end
      if (!(pr1 && !g1 && $urandom_range(9) != 0)) begin
        pr1 = $urandom_range(9) < 6; pw1 = 1'($urandom_range(1));
        pa1 = {26'd0, 4'($urandom_range(15)), 2'b00}; pd1 = $urandom;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
